// File: rtl/mem_access_controller_pkg.sv
// ============================================================================
// mem_access_controller_pkg : shared state encoding and helpers for the
// memory-stage bus controller.  Revision: 1.0
// ============================================================================
`default_nettype none

package mem_access_controller_pkg;

  localparam int unsigned MAC_DATA_W = 32;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_BUSY = 2'd1,
    MAC_DONE = 2'd2
  } mac_state_e;

  function automatic logic mac_is_misaligned(input logic [1:0] byte_offset);
    return byte_offset != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_controller_timeout.sv
// ============================================================================
// mac_timeout_counter : counts BUSY cycles and flags the cycle in which the
// TIMEOUT_CYCLES-th wait cycle is reached.  Revision: 1.0
// ============================================================================
`default_nettype none

module mac_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] count_q;
  logic [c_cnt_w-1:0] count_d;

  // Expires during the final permitted wait cycle, so the FSM leaves BUSY
  // after exactly TIMEOUT_CYCLES cycles of request.
  assign o_expired = i_enable && (count_q == c_last);

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && !o_expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_controller.sv
// ============================================================================
// mem_access_controller : MEM-stage req/ack bus controller with pipeline
// stall, load-data return, timeout and misalignment flags.  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  memread_mem,
  input  logic                  memwrite_mem,
  input  logic [31:0]           alu_result_mem,
  input  logic [31:0]           write_data_memory_mem,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [31:0]           data_from_memory_mem,
  output logic                  data_ready_mem,
  output logic                  err_timeout,
  output logic                  err_misaligned
);

  mac_state_e                state_q, state_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [MAC_DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [MAC_DATA_W-1:0]     rdata_q, rdata_d;
  logic                      err_timeout_q, err_timeout_d;
  logic                      err_misaligned_q, err_misaligned_d;
  logic                      access;
  logic                      tmo_expired;

  assign access = memread_mem | memwrite_mem;

  generate
    if (ADDR_WIDTH < 30) begin : g_unused_addr_bits
      logic unused_addr_hi;
      assign unused_addr_hi = ^alu_result_mem[31:ADDR_WIDTH+2];
    end
  endgenerate

  mac_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rstn     (rstn),
    .i_clear  (state_q != MAC_BUSY),
    .i_enable (state_q == MAC_BUSY),
    .o_expired(tmo_expired)
  );

  always_comb begin
    state_d          = state_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    rdata_d          = rdata_q;
    err_timeout_d    = err_timeout_q;
    err_misaligned_d = err_misaligned_q;
    data_ready_mem   = 1'b0;

    case (state_q)
      MAC_IDLE: begin
        data_ready_mem = ~access;
        if (access) begin
          // A store takes precedence when both strobes are set.
          mem_we_d    = memwrite_mem;
          mem_addr_d  = alu_result_mem[ADDR_WIDTH+1:2];
          mem_wdata_d = write_data_memory_mem;
          mem_req_d   = 1'b1;
          state_d     = MAC_BUSY;
          if (mac_is_misaligned(alu_result_mem[1:0])) begin
            err_misaligned_d = 1'b1;
          end
        end
      end
      MAC_BUSY: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          state_d   = MAC_DONE;
        end else if (tmo_expired) begin
          err_timeout_d = 1'b1;
          rdata_d       = '0;
          mem_req_d     = 1'b0;
          state_d       = MAC_DONE;
        end
      end
      MAC_DONE: begin
        data_ready_mem = 1'b1;
        state_d        = MAC_IDLE;
      end
      default: begin
        state_d = MAC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= MAC_IDLE;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      rdata_q          <= '0;
      err_timeout_q    <= 1'b0;
      err_misaligned_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      rdata_q          <= rdata_d;
      err_timeout_q    <= err_timeout_d;
      err_misaligned_q <= err_misaligned_d;
    end
  end

  assign mem_req              = mem_req_q;
  assign mem_we               = mem_we_q;
  assign mem_addr             = mem_addr_q;
  assign mem_wdata            = mem_wdata_q;
  assign data_from_memory_mem = rdata_q;
  assign err_timeout          = err_timeout_q;
  assign err_misaligned       = err_misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_controller.sv
// ============================================================================
// tb_mem_access_controller : directed stimulus with a queue-based scoreboard
// for mem_access_controller.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_controller;

  localparam int unsigned AW  = 15;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          memread_mem = 1'b0;
  logic          memwrite_mem = 1'b0;
  logic [31:0]   alu_result_mem = '0;
  logic [31:0]   write_data_memory_mem = '0;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   data_from_memory_mem;
  logic          data_ready_mem;
  logic          err_timeout;
  logic          err_misaligned;

  mem_access_controller #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .memread_mem          (memread_mem),
    .memwrite_mem         (memwrite_mem),
    .alu_result_mem       (alu_result_mem),
    .write_data_memory_mem(write_data_memory_mem),
    .mem_ack              (mem_ack),
    .mem_rdata            (mem_rdata),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .data_from_memory_mem (data_from_memory_mem),
    .data_ready_mem       (data_ready_mem),
    .err_timeout          (err_timeout),
    .err_misaligned       (err_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          stall;
    int          req_cycles;
    logic [31:0] data;
    logic        err_to;
    logic        err_mis;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Bus responder controls
  int          ack_delay = 0;
  logic [31:0] rdata_val = '0;
  logic        force_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Responder: acks on the ack_delay-th cycle of an asserted request.
  int req_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (mem_req) req_cnt = req_cnt + 1;
    else req_cnt = 0;
    mem_ack   = ((ack_delay != 0) && mem_req && (req_cnt == ack_delay)) || force_ack;
    mem_rdata = rdata_val;
  end

  // Monitor / scoreboard
  logic     prev_req = 1'b0;
  int       stall = 0;
  int       req_cycles = 0;
  bus_exp_t cur_bus;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_req   = 1'b0;
      stall      = 0;
      req_cycles = 0;
    end else begin
      if (mem_req) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) begin
            check("unexpected_req_count", 32'(bus_q.size()), 32'd1);
            cur_bus = '{1'b0, 32'h0, 32'h0};
          end else begin
            cur_bus = bus_q.pop_front();
          end
        end
        check("bus_we", {31'b0, mem_we}, {31'b0, cur_bus.we});
        check("bus_addr", 32'(mem_addr), cur_bus.addr);
        check("bus_wdata", mem_wdata, cur_bus.wdata);
        req_cycles++;
      end
      if (!data_ready_mem) begin
        stall++;
      end else if (stall > 0) begin
        if (done_q.size() == 0) begin
          check("unexpected_done_count", 32'(done_q.size()), 32'd1);
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          check("stall_cycles", 32'(stall), 32'(e.stall));
          check("req_cycles", 32'(req_cycles), 32'(e.req_cycles));
          check("load_data", data_from_memory_mem, e.data);
          check("err_timeout", {31'b0, err_timeout}, {31'b0, e.err_to});
          check("err_misaligned", {31'b0, err_misaligned}, {31'b0, e.err_mis});
        end
        stall      = 0;
        req_cycles = 0;
      end
      prev_req = mem_req;
    end
  end

  task automatic set_idle();
    memread_mem           = 1'b0;
    memwrite_mem          = 1'b0;
    alu_result_mem        = '0;
    write_data_memory_mem = '0;
  endtask

  // Presents one MEM-stage instruction and holds it until the pipeline advances.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int dly);
    int n;
    memread_mem           = rd;
    memwrite_mem          = wr;
    alu_result_mem        = addr;
    write_data_memory_mem = wdata;
    rdata_val             = rdata;
    ack_delay             = dly;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!data_ready_mem && n < 40);
    if (!data_ready_mem) check("ready_timeout", 32'(data_ready_mem), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_data"}, data_from_memory_mem, 32'd0);
    check({tag, "_ready"}, {31'b0, data_ready_mem}, 32'd1);
    check({tag, "_err_to"}, {31'b0, err_timeout}, 32'd0);
    check({tag, "_err_mis"}, {31'b0, err_misaligned}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Load with ack on the 3rd request cycle
    bus_q.push_back('{1'b0, 32'd4, 32'h0});
    done_q.push_back('{4, 3, 32'hDEAD_BEEF, 1'b0, 1'b0});
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3);
    set_idle();

    // Store with ack on the first request cycle; load data untouched
    bus_q.push_back('{1'b1, 32'd2, 32'h1234_5678});
    done_q.push_back('{2, 1, 32'hDEAD_BEEF, 1'b0, 1'b0});
    do_access(1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h5555_5555, 1);
    set_idle();
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back loads
    bus_q.push_back('{1'b0, 32'd0, 32'h0});
    done_q.push_back('{2, 1, 32'hA5A5_0001, 1'b0, 1'b0});
    bus_q.push_back('{1'b0, 32'd1, 32'h0});
    done_q.push_back('{3, 2, 32'h5A5A_0002, 1'b0, 1'b0});
    do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_0001, 1);
    do_access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h5A5A_0002, 2);
    set_idle();

    // No ack: abandoned after TMO request cycles
    bus_q.push_back('{1'b0, 32'd8, 32'h0});
    done_q.push_back('{TMO + 1, TMO, 32'h0, 1'b1, 1'b0});
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h7777_7777, 0);
    set_idle();
    @(negedge clk);
    check("err_timeout_sticky", {31'b0, err_timeout}, 32'd1);
    check("idle_ready", {31'b0, data_ready_mem}, 32'd1);
    @(posedge clk);
    #1;

    // Reset while BUSY, then a stray ack in IDLE
    bus_q.push_back('{1'b0, 32'd16, 32'h0});
    memread_mem    = 1'b1;
    alu_result_mem = 32'h0000_0040;
    rdata_val      = 32'hBAD0_BAD0;
    ack_delay      = 0;
    repeat (3) @(negedge clk);
    check("busy_ready_low", {31'b0, data_ready_mem}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    set_idle();
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");
    @(posedge clk);
    #1;

    // Misaligned, both strobes: performed as a store at word 1
    bus_q.push_back('{1'b1, 32'd1, 32'hCAFE_F00D});
    done_q.push_back('{2, 1, 32'h0, 1'b0, 1'b1});
    do_access(1'b1, 1'b1, 32'h0000_0006, 32'hCAFE_F00D, 32'h1111_1111, 1);
    set_idle();

    repeat (4) @(posedge clk);
    #1;
    check("bus_q_left", 32'(bus_q.size()), 32'd0);
    check("done_q_left", 32'(done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
